// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch stage: instruction encodings,
// branch immediate field positions and the next-PC selection enum.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  // Immediate fields inside the instruction word.
  localparam int IMM26_MSB = 25;
  localparam int IMM26_LSB = 0;
  localparam int IMM26_W   = IMM26_MSB - IMM26_LSB + 1;
  localparam int IMM19_MSB = 23;
  localparam int IMM19_LSB = 5;
  localparam int IMM19_W   = IMM19_MSB - IMM19_LSB + 1;

  localparam int PC_INCR = 4;

  typedef enum logic [1:0] {
    SEQ,
    BRANCH,
    HOLD
  } next_pc_sel_e;

endpackage : cpu_pkg

// File: rtl/branch_target_gen.sv
// Combinational branch target: sign-extend the B or B.cond/CBZ immediate,
// scale it to a byte offset and add it to the branch's own PC.
module branch_target_gen
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [IMM26_MSB:0]  imm_field,
  input  logic [ADDR_W-1:0]   pc,
  input  logic                uncond_br,
  output logic [ADDR_W-1:0]   target
);

  logic [IMM26_W-1:0] imm26;
  logic [IMM19_W-1:0] imm19;
  logic [ADDR_W-1:0]  offset;

  assign imm26 = imm_field[IMM26_MSB:IMM26_LSB];
  assign imm19 = imm_field[IMM19_MSB:IMM19_LSB];

  // Offsets are word counts; the two appended zeros turn them into bytes.
  assign offset = uncond_br
                ? {{(ADDR_W-IMM26_W-2){imm26[IMM26_W-1]}}, imm26, 2'b00}
                : {{(ADDR_W-IMM19_W-2){imm19[IMM19_W-1]}}, imm19, 2'b00};

  assign target = pc + offset;

endmodule : branch_target_gen

// File: rtl/fetch_stage.sv
// Instruction fetch plus IF/ID pipeline register: PC update, branch redirect
// with one-bubble squash, load-use stall and instruction-memory wait states.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          ADDR_W   = 64,
  parameter int          INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  input  logic               stall,
  input  logic               br_taken,
  input  logic               uncond_br,
  output logic [INSTR_W-1:0] instr_id,
  output logic [ADDR_W-1:0]  pc_id,
  output logic               valid_id,
  output logic [31:0]        instr_count
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] br_target;
  next_pc_sel_e      pc_sel;

  assign imem_addr = pc;

  branch_target_gen #(
    .ADDR_W (ADDR_W)
  ) u_branch_target_gen (
    .imm_field (instr_id[IMM26_MSB:0]),
    .pc        (pc_id),
    .uncond_br (uncond_br),
    .target    (br_target)
  );

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    pc_sel = SEQ;
    if (stall) begin
      pc_sel = HOLD;
    end else if (br_taken && valid_id) begin
      pc_sel = BRANCH;
    end else if (!imem_valid) begin
      pc_sel = HOLD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= ADDR_W'(RESET_PC);
      instr_id    <= INSTR_W'(NOP_INSTR);
      pc_id       <= '0;
      valid_id    <= 1'b0;
      instr_count <= '0;
    end else if (!stall) begin
      // A stall freezes everything, including a pending branch in decode.
      case (pc_sel)
        BRANCH:  pc <= br_target;
        SEQ:     pc <= pc + ADDR_W'(PC_INCR);
        default: pc <= pc;
      endcase
      if (pc_sel == SEQ) begin
        instr_id    <= imem_rdata;
        pc_id       <= pc;
        valid_id    <= 1'b1;
        instr_count <= instr_count + 32'd1;
      end else begin
        // Redirect squashes the wrong-path fetch; a memory wait inserts a bubble.
        instr_id <= INSTR_W'(NOP_INSTR);
        pc_id    <= '0;
        valid_id <= 1'b0;
      end
    end
  end

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: sequential fetch, B and CBZ
// redirects, stall freezing a pending branch, memory waits, async reset, PC wrap.
module tb_fetch_stage;

  localparam logic [31:0] NOP   = 32'hD503201F;
  localparam logic [31:0] ADD   = 32'h8B020020;
  localparam logic [31:0] B_P3  = 32'h14000003;  // B #+3 words
  localparam logic [31:0] B_M1  = 32'h17FFFFFF;  // B #-1 word
  localparam logic [31:0] B_M2  = 32'h17FFFFFE;  // B #-2 words
  localparam logic [31:0] CBZ_M2 = 32'hB4FFFFC0; // CBZ X0, imm19=-2

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        br_taken;
  logic        uncond_br;
  logic [31:0] instr_id;
  logic [63:0] pc_id;
  logic        valid_id;
  logic [31:0] instr_count;

  int asserts = 0;
  int fails   = 0;

  fetch_stage #(
    .RESET_PC (64'h0),
    .ADDR_W   (64),
    .INSTR_W  (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .stall       (stall),
    .br_taken    (br_taken),
    .uncond_br   (uncond_br),
    .instr_id    (instr_id),
    .pc_id       (pc_id),
    .valid_id    (valid_id),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs change here, away from the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; imem_valid = 1'b1; imem_rdata = ADD;
    stall = 1'b0; br_taken = 1'b0; uncond_br = 1'b0;
    cycle(); cycle();
    asserts++; if (imem_addr !== 64'd0) begin fails++; $display("FAIL reset_addr: got %h exp %h", imem_addr, 64'd0); end
    asserts++; if (instr_id !== NOP) begin fails++; $display("FAIL reset_instr: got %h exp %h", instr_id, NOP); end
    asserts++; if (pc_id !== 64'd0) begin fails++; $display("FAIL reset_pc_id: got %h exp 0", pc_id); end
    asserts++; if (valid_id !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b exp 0", valid_id); end
    asserts++; if (instr_count !== 32'd0) begin fails++; $display("FAIL reset_count: got %0d exp 0", instr_count); end
    #2 reset = 1'b1;
  endtask

  task automatic test_sequential();
    cycle();
    asserts++; if (imem_addr !== 64'd4) begin fails++; $display("FAIL seq_addr1: got %h exp 4", imem_addr); end
    asserts++; if (instr_id !== ADD) begin fails++; $display("FAIL seq_instr1: got %h exp %h", instr_id, ADD); end
    asserts++; if (pc_id !== 64'd0) begin fails++; $display("FAIL seq_pc_id1: got %h exp 0", pc_id); end
    asserts++; if (valid_id !== 1'b1) begin fails++; $display("FAIL seq_valid1: got %b exp 1", valid_id); end
    asserts++; if (instr_count !== 32'd1) begin fails++; $display("FAIL seq_count1: got %0d exp 1", instr_count); end
    cycle();
    asserts++; if (imem_addr !== 64'd8) begin fails++; $display("FAIL seq_addr2: got %h exp 8", imem_addr); end
    asserts++; if (pc_id !== 64'd4) begin fails++; $display("FAIL seq_pc_id2: got %h exp 4", pc_id); end
    asserts++; if (instr_count !== 32'd2) begin fails++; $display("FAIL seq_count2: got %0d exp 2", instr_count); end
  endtask

  task automatic test_branch_b();
    imem_rdata = B_P3;
    cycle();  // B enters decode at pc_id=8
    asserts++; if (pc_id !== 64'd8) begin fails++; $display("FAIL b_pc_id: got %h exp 8", pc_id); end
    asserts++; if (instr_count !== 32'd3) begin fails++; $display("FAIL b_count_in: got %0d exp 3", instr_count); end
    br_taken = 1'b1; uncond_br = 1'b1; imem_rdata = ADD;
    cycle();
    asserts++; if (imem_addr !== 64'd20) begin fails++; $display("FAIL b_target: got %h exp 14", imem_addr); end
    asserts++; if (instr_id !== NOP) begin fails++; $display("FAIL b_squash_instr: got %h exp %h", instr_id, NOP); end
    asserts++; if (valid_id !== 1'b0) begin fails++; $display("FAIL b_squash_valid: got %b exp 0", valid_id); end
    asserts++; if (instr_count !== 32'd3) begin fails++; $display("FAIL b_squash_count: got %0d exp 3", instr_count); end
    // br_taken left high: a bubble in decode must ignore it.
    imem_rdata = B_M1;
    cycle();
    asserts++; if (pc_id !== 64'd20) begin fails++; $display("FAIL b_resume_pc_id: got %h exp 14", pc_id); end
    asserts++; if (imem_addr !== 64'd24) begin fails++; $display("FAIL b_resume_addr: got %h exp 18", imem_addr); end
    asserts++; if (instr_count !== 32'd4) begin fails++; $display("FAIL b_resume_count: got %0d exp 4", instr_count); end
    cycle();  // B #-1 at pc_id=20 redirects to 16
    asserts++; if (imem_addr !== 64'd16) begin fails++; $display("FAIL b_back_target: got %h exp 10", imem_addr); end
    br_taken = 1'b0;
  endtask

  task automatic test_cbz();
    imem_rdata = CBZ_M2;
    cycle();
    asserts++; if (instr_id !== CBZ_M2 || pc_id !== 64'd16) begin fails++; $display("FAIL cbz_decode: got %h@%h exp %h@10", instr_id, pc_id, CBZ_M2); end
    br_taken = 1'b1; uncond_br = 1'b0; imem_rdata = ADD;
    cycle();
    asserts++; if (imem_addr !== 64'd8) begin fails++; $display("FAIL cbz_target: got %h exp 8", imem_addr); end
    asserts++; if (valid_id !== 1'b0) begin fails++; $display("FAIL cbz_bubble: got %b exp 0", valid_id); end
    br_taken = 1'b0;
    cycle();
    asserts++; if (valid_id !== 1'b1 || pc_id !== 64'd8) begin fails++; $display("FAIL cbz_resume: got v=%b pc_id=%h exp v=1 pc_id=8", valid_id, pc_id); end
    asserts++; if (instr_count !== 32'd6) begin fails++; $display("FAIL cbz_count: got %0d exp 6", instr_count); end
  endtask

  task automatic test_stall();
    imem_rdata = B_P3;
    cycle();  // B at pc_id=12, pc=16, count 7
    stall = 1'b1; br_taken = 1'b1; uncond_br = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      asserts++; if (imem_addr !== 64'd16) begin fails++; $display("FAIL stall_addr[%0d]: got %h exp 10", i, imem_addr); end
      asserts++; if (instr_id !== B_P3 || valid_id !== 1'b1) begin fails++; $display("FAIL stall_ifid[%0d]: got %h v=%b exp %h v=1", i, instr_id, valid_id, B_P3); end
      asserts++; if (instr_count !== 32'd7) begin fails++; $display("FAIL stall_count[%0d]: got %0d exp 7", i, instr_count); end
    end
    stall = 1'b0;
    cycle();
    asserts++; if (imem_addr !== 64'd24) begin fails++; $display("FAIL stall_redirect: got %h exp 18", imem_addr); end
    asserts++; if (valid_id !== 1'b0) begin fails++; $display("FAIL stall_bubble: got %b exp 0", valid_id); end
    br_taken = 1'b0;
  endtask

  task automatic test_imem_wait();
    imem_rdata = ADD; imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      asserts++; if (imem_addr !== 64'd24) begin fails++; $display("FAIL wait_addr[%0d]: got %h exp 18", i, imem_addr); end
      asserts++; if (valid_id !== 1'b0) begin fails++; $display("FAIL wait_valid[%0d]: got %b exp 0", i, valid_id); end
      asserts++; if (instr_count !== 32'd7) begin fails++; $display("FAIL wait_count[%0d]: got %0d exp 7", i, instr_count); end
    end
    imem_valid = 1'b1;
    cycle();
    asserts++; if (pc_id !== 64'd24 || imem_addr !== 64'd28) begin fails++; $display("FAIL wait_resume: got pc_id=%h addr=%h exp 18/1c", pc_id, imem_addr); end
    asserts++; if (instr_count !== 32'd8) begin fails++; $display("FAIL wait_resume_count: got %0d exp 8", instr_count); end
  endtask

  task automatic test_reset_mid();
    imem_rdata = B_P3;
    cycle();  // B in decode at pc_id=28
    br_taken = 1'b1; uncond_br = 1'b1;
    #3 reset = 1'b0;
    #1;
    asserts++; if (imem_addr !== 64'd0) begin fails++; $display("FAIL mid_reset_addr: got %h exp 0", imem_addr); end
    asserts++; if (instr_id !== NOP || valid_id !== 1'b0) begin fails++; $display("FAIL mid_reset_ifid: got %h v=%b exp %h v=0", instr_id, valid_id, NOP); end
    asserts++; if (instr_count !== 32'd0 || pc_id !== 64'd0) begin fails++; $display("FAIL mid_reset_count: got %0d pc_id=%h exp 0/0", instr_count, pc_id); end
    br_taken = 1'b0; imem_rdata = ADD;
    #2 reset = 1'b1;
    cycle();
    asserts++; if (pc_id !== 64'd0 || valid_id !== 1'b1 || imem_addr !== 64'd4) begin fails++; $display("FAIL mid_reset_refetch: got pc_id=%h v=%b addr=%h exp 0/1/4", pc_id, valid_id, imem_addr); end
    asserts++; if (instr_count !== 32'd1) begin fails++; $display("FAIL mid_reset_count1: got %0d exp 1", instr_count); end
  endtask

  task automatic test_pc_wrap();
    imem_rdata = B_M2;
    cycle();  // B #-2 at pc_id=4 targets 4-8 = ...FFFC
    br_taken = 1'b1; uncond_br = 1'b1;
    cycle();
    asserts++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin fails++; $display("FAIL wrap_target: got %h exp fffffffffffffffc", imem_addr); end
    br_taken = 1'b0; imem_rdata = ADD;
    cycle();
    asserts++; if (imem_addr !== 64'd0) begin fails++; $display("FAIL wrap_addr: got %h exp 0", imem_addr); end
    asserts++; if (pc_id !== 64'hFFFF_FFFF_FFFF_FFFC) begin fails++; $display("FAIL wrap_pc_id: got %h exp fffffffffffffffc", pc_id); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_b();
    test_cbz();
    test_stall();
    test_imem_wait();
    test_reset_mid();
    test_pc_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule : tb_fetch_stage
